// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC and a synchronous instruction memory.
// A small fetch queue feeds decode through a valid/ready handshake, and a redirect path flushes it.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 1024,
  parameter int              FQ_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_pc_nxt,
  output logic [XLEN-1:0]               out_instr,
  output logic                          out_fault,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [XLEN-1:0] DEPTH_X = XLEN'(IMEM_DEPTH);
  localparam logic [CW:0]     LIMIT   = (CW+1)'(FQ_DEPTH);

  logic [XLEN-1:0] mem [IMEM_DEPTH];

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_fault;

  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [XLEN-1:0] q_instr [FQ_DEPTH];
  logic            q_fault [FQ_DEPTH];
  logic [QW-1:0]   rd_ptr;
  logic [QW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            pop;
  logic            issue;
  logic            in_range;
  logic [CW:0]     occupancy;

  // Occupancy counts the in-flight read as already owning a queue slot, so the queue cannot overflow.
  always_comb begin
    pop       = out_valid & out_ready;
    in_range  = fetch_pc < DEPTH_X;
    occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue     = !redirect_valid && (occupancy < LIMIT);
  end

  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (inflight) begin
        q_pc[wr_ptr]    <= if_pc;
        q_instr[wr_ptr] <= if_instr;
        q_fault[wr_ptr] <= if_fault;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count + CW'(inflight) - CW'(pop);
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 1'b1;
        if_pc    <= fetch_pc;
        if_fault <= !in_range;
        if_instr <= in_range ? mem[fetch_pc[AW-1:0]] : NOP_INSTR;
      end
    end
  end

  always_comb begin
    out_valid  = (count != '0);
    out_pc     = out_valid ? q_pc[rd_ptr]         : '0;
    out_pc_nxt = out_valid ? q_pc[rd_ptr] + 1'b1  : '0;
    out_instr  = out_valid ? q_instr[rd_ptr]      : '0;
    out_fault  = out_valid ? q_fault[rd_ptr]      : 1'b0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the pipeline corner cases,
// then randomized traffic checked against a transaction-level queue model.
module tb_fetch_unit;

  localparam int DEPTH = 1024;
  localparam int FQD   = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_nxt;
  logic [31:0] out_instr;
  logic        out_fault;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .XLEN(32), .IMEM_DEPTH(DEPTH), .FQ_DEPTH(FQD), .RESET_PC(32'h0), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_pc_nxt(out_pc_nxt),
    .out_instr(out_instr), .out_fault(out_fault), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ef;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  vec_t        vecs [35];
  logic [31:0] model_mem [DEPTH];
  ent_t        mq [$];
  logic        m_inflight;
  ent_t        m_if;
  logic [31:0] m_pc;

  function automatic logic [31:0] memval(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic ef);
    vec_t v;
    v.rst_n = rst_n; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.ef = ef;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic ef);
    logic [31:0] nxt;
    nxt = ev ? epc + 32'd1 : 32'd0;
    check_val({tag, ".valid"}, {31'b0, out_valid}, {31'b0, ev});
    check_val({tag, ".pc"}, out_pc, ev ? epc : 32'd0);
    check_val({tag, ".pc_nxt"}, out_pc_nxt, nxt);
    check_val({tag, ".instr"}, out_instr, ev ? einstr : 32'd0);
    check_val({tag, ".fault"}, {31'b0, out_fault}, {31'b0, ev & ef});
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic rv, input logic [31:0] rpc,
                                input logic rdy);
    rst            = rst_n;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  // Queue-level reference: decode sees fetches in PC order, restarted by reset or redirect,
  // with one read allowed to be outstanding as long as it has a guaranteed slot.
  task automatic model_step(input logic rst_n, input logic rv, input logic [31:0] rpc,
                            input logic rdy, input logic we, input logic [9:0] wa,
                            input logic [31:0] wd);
    bit pop;
    int occ;
    if (!rst_n) begin
      mq.delete();
      m_inflight = 1'b0;
      m_pc       = 32'h0;
    end else if (rv) begin
      mq.delete();
      m_inflight = 1'b0;
      m_pc       = rpc;
    end else begin
      pop = (mq.size() > 0) && rdy;
      occ = mq.size() + int'(m_inflight) - int'(pop);
      if (pop) void'(mq.pop_front());
      if (m_inflight) mq.push_back(m_if);
      m_inflight = (occ < FQD);
      if (m_inflight) begin
        m_if.pc    = m_pc;
        m_if.fault = (m_pc >= 32'(DEPTH));
        m_if.instr = m_if.fault ? NOP : model_mem[m_pc[9:0]];
        m_pc       = m_pc + 32'd1;
      end
    end
    if (we) model_mem[wa] = wd;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 1, 0, memval(0), 0);
    vecs[2]  = mk(1, 0, 0, 1, 1, 1, memval(1), 0);
    vecs[3]  = mk(1, 0, 0, 1, 1, 2, memval(2), 0);
    vecs[4]  = mk(1, 0, 0, 1, 1, 3, memval(3), 0);
    vecs[5]  = mk(1, 0, 0, 1, 1, 4, memval(4), 0);
    vecs[6]  = mk(1, 1, 0, 1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 1, 0, memval(0), 0);
    for (int i = 9; i <= 13; i++) vecs[i] = mk(1, 0, 0, 0, 1, 0, memval(0), 0);
    vecs[14] = mk(1, 0, 0, 1, 1, 1, memval(1), 0);
    vecs[15] = mk(1, 0, 0, 1, 1, 2, memval(2), 0);
    vecs[16] = mk(1, 1, 8, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 1, 8, memval(8), 0);
    vecs[19] = mk(1, 0, 0, 0, 1, 8, memval(8), 0);
    vecs[20] = mk(1, 1, 1023, 1, 0, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 1, 1, 1023, memval(1023), 0);
    vecs[23] = mk(1, 0, 0, 1, 1, 1024, NOP, 1);
    vecs[24] = mk(1, 0, 0, 0, 1, 1024, NOP, 1);
    vecs[25] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    vecs[26] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    vecs[27] = mk(1, 0, 0, 1, 1, 0, memval(0), 0);
    vecs[28] = mk(1, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    vecs[29] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    vecs[30] = mk(1, 0, 0, 1, 1, 32'hFFFF_FFFF, NOP, 1);
    vecs[31] = mk(1, 0, 0, 1, 1, 0, memval(0), 0);
    vecs[32] = mk(0, 1, 5, 1, 0, 0, 0, 0);
    vecs[33] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    vecs[34] = mk(1, 0, 0, 1, 1, 0, memval(0), 0);

    apply_stimulus(0, 0, 0, 0);
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;

    // Load the whole memory while held in reset.
    for (int i = 0; i < DEPTH; i++) begin
      imem_we      = 1'b1;
      imem_waddr   = 10'(i);
      imem_wdata   = memval(i);
      model_mem[i] = memval(i);
      @(posedge clk);
      #1;
    end
    imem_we = 1'b0;
    @(posedge clk);
    #1;
    check_output("reset", 0, 0, 0, 0);

    for (int i = 0; i < 35; i++) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr, vecs[i].ef);
    end

    apply_stimulus(0, 0, 0, 0);
    @(posedge clk);
    model_step(0, 0, 0, 0, 0, 0, 0);
    #1;

    for (int c = 0; c < 3000; c++) begin
      logic        r_rst;
      logic        r_rv;
      logic [31:0] r_pc;
      logic        r_rdy;
      r_rst = ($urandom_range(0, 63) != 0);
      r_rv  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       r_pc = 32'($urandom_range(0, 31));
        1:       r_pc = 32'($urandom_range(1015, 1030));
        2:       r_pc = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: r_pc = $urandom;
      endcase
      r_rdy      = ($urandom_range(0, 3) != 0);
      imem_we    = ($urandom_range(0, 3) == 0);
      imem_waddr = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31))
                                              : 10'($urandom_range(1000, 1023));
      imem_wdata = $urandom;
      apply_stimulus(r_rst, r_rv, r_pc, r_rdy);
      @(posedge clk);
      model_step(r_rst, r_rv, r_pc, r_rdy, imem_we, imem_waddr, imem_wdata);
      #1;
      if (mq.size() > 0)
        check_output("rand", 1'b1, mq[0].pc, mq[0].instr, mq[0].fault);
      else
        check_output("rand", 1'b0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
